// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD event counter driven by the clock divider's tick strobe, with run/stop toggle,
// synchronous clear and terminal-count pulse. Define TICK_COUNTER_DOWN_EN to honour the dir input.
module tick_bcd_counter #(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  btn_run,
    input  logic                  clr,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  term_pulse
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state;
    state_t       state_n;
    logic         btn_prev;
    logic         run_edge;
    logic         term_n;
    logic [W-1:0] bcd_n;
    logic [W-1:0] inc_val;
    logic [W-1:0] step_val;
    logic [W-1:0] wrap_val;
    logic         at_term;

    assign run_edge = btn_run & ~btn_prev;

    always_comb begin
        logic carry;
        inc_val = bcd;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

`ifdef TICK_COUNTER_DOWN_EN
    logic [W-1:0] dec_val;

    always_comb begin
        logic borrow;
        dec_val = bcd;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (bcd[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // dir only matters on tick cycles, where these selections are consumed.
    assign at_term  = dir ? (bcd == '0) : (bcd == ALL_NINES);
    assign step_val = dir ? dec_val : inc_val;
    assign wrap_val = dir ? ALL_NINES : '0;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign at_term    = (bcd == ALL_NINES);
    assign step_val   = inc_val;
    assign wrap_val   = '0;
`endif

    always_comb begin
        state_n = state;
        bcd_n   = bcd;
        term_n  = 1'b0;
        if (clr) begin
            state_n = IDLE;
            bcd_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_edge) state_n = RUN;
                end
                RUN: begin
                    if (tick) begin
                        if (at_term) begin
                            term_n = 1'b1;
                            if (WRAP != 0) bcd_n = wrap_val;
                            else           state_n = HOLD;
                        end else begin
                            bcd_n = step_val;
                        end
                    end
                    // Saturation wins over a simultaneous stop request.
                    if (run_edge && state_n == RUN) state_n = IDLE;
                end
                HOLD: state_n = HOLD;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            btn_prev   <= 1'b1;
            bcd        <= '0;
            running    <= 1'b0;
            term_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            btn_prev   <= btn_run;
            bcd        <= bcd_n;
            running    <= (state_n == RUN);
            term_pulse <= term_n;
        end
    end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Bench for tick_bcd_counter: a WRAP=0 and a WRAP=1 instance share stimulus; a decimal
// reference model feeds an expected queue checked every cycle, plus directed checks per scenario.
module tb_tick_bcd_counter;

`ifdef TICK_COUNTER_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, tick, btn_run, clr, dir;
    logic [7:0] bcd0, bcd1;
    logic       running0, running1, term0, term1;

    tick_bcd_counter #(.DIGITS(2), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .tick(tick), .btn_run(btn_run), .clr(clr), .dir(dir),
        .bcd(bcd0), .running(running0), .term_pulse(term0)
    );

    tick_bcd_counter #(.DIGITS(2), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .tick(tick), .btn_run(btn_run), .clr(clr), .dir(dir),
        .bcd(bcd1), .running(running1), .term_pulse(term1)
    );

    always #5 clk = ~clk;

    wire [19:0] obs = {term1, running1, bcd1, term0, running0, bcd0};

    logic [19:0] exp_q[$];
    logic [19:0] exp_v;
    int          checks = 0;
    int          passes = 0;

    // Reference model: index 0 saturates, index 1 wraps. States 0=idle 1=run 2=hold.
    int   m_cnt[2];
    int   m_st[2];
    logic m_term[2];
    logic m_prev;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic logic [19:0] model_pack();
        return {m_term[1], m_st[1] == 1, to_bcd(m_cnt[1]), m_term[0], m_st[0] == 1, to_bcd(m_cnt[0])};
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_cnt[w] = 0; m_st[w] = 0; m_term[w] = 1'b0;
        end
        m_prev = 1'b1;
    endtask

    task automatic model_step(input logic t, input logic b, input logic c);
        logic rise;
        bit   down;
        rise   = b & ~m_prev;
        m_prev = b;
        down   = DOWN_EN && dir;
        for (int w = 0; w < 2; w++) begin
            m_term[w] = 1'b0;
            if (c) begin
                m_cnt[w] = 0; m_st[w] = 0;
            end else if (m_st[w] == 0) begin
                if (rise) m_st[w] = 1;
            end else if (m_st[w] == 1) begin
                if (t) begin
                    if (!down && m_cnt[w] == 99) begin
                        m_term[w] = 1'b1;
                        if (w == 1) m_cnt[w] = 0; else m_st[w] = 2;
                    end else if (down && m_cnt[w] == 0) begin
                        m_term[w] = 1'b1;
                        if (w == 1) m_cnt[w] = 99; else m_st[w] = 2;
                    end else begin
                        m_cnt[w] = down ? m_cnt[w] - 1 : m_cnt[w] + 1;
                    end
                end
                if (rise && m_st[w] == 1) m_st[w] = 0;
            end
        end
    endtask

    // Driver: apply one cycle of inputs, queue the expected outputs for the edge that consumes them.
    task automatic drive(input logic t, input logic b, input logic c);
        tick = t; btn_run = b; clr = c;
        model_step(t, b, c);
        @(posedge clk);
        exp_q.push_back(model_pack());
        #1;
    endtask

    // Scoreboard: outputs are compared half a cycle after the edge that produced them.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (obs === exp_v) passes++;
            else $display("FAIL scoreboard @%0t: got %h want %h", $time, obs, exp_v);
        end
    end

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; btn_run = 1'b1; clr = 1'b0; dir = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs === 20'h0) passes++;
        else $display("FAIL reset_values: got %h want 00000", obs);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (running0 === 1'b0 && running1 === 1'b0) passes++;
        else $display("FAIL held_button: running got %b/%b want 0/0", running0, running1);
    endtask

    task automatic test_count_up();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (running0 === 1'b1 && running1 === 1'b1) passes++;
        else $display("FAIL run_edge: running got %b/%b want 1/1", running0, running1);
        repeat (12) drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bcd0 === 8'h12 && bcd1 === 8'h12) passes++;
        else $display("FAIL count12: bcd got %h/%h want 12/12", bcd0, bcd1);
    endtask

    task automatic test_terminal();
        repeat (87) drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bcd0 === 8'h99 && bcd1 === 8'h99) passes++;
        else $display("FAIL preload99: bcd got %h/%h want 99/99", bcd0, bcd1);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if ({term1, running1, bcd1} === {1'b1, 1'b1, 8'h00} && {term0, running0, bcd0} === {1'b1, 1'b0, 8'h99})
            passes++;
        else $display("FAIL terminal: wrap got %b%b%h want 1100 sat got %b%b%h want 1099",
                      term1, running1, bcd1, term0, running0, bcd0);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (term0 === 1'b0 && term1 === 1'b0 && bcd1 === 8'h01) passes++;
        else $display("FAIL term_single: term got %b/%b bcd1 %h want 0/0 01", term0, term1, bcd1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bcd0 === 8'h99 && running0 === 1'b0 && term0 === 1'b0) passes++;
        else $display("FAIL hold_ignores_btn: got %h run %b term %b want 99 0 0", bcd0, running0, term0);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (bcd0 === 8'h00 && bcd1 === 8'h00 && running0 === 1'b0 && running1 === 1'b0) passes++;
        else $display("FAIL clear: bcd got %h/%h run %b/%b want 00/00 0/0", bcd0, bcd1, running0, running1);
    endtask

    task automatic test_collision();
        drive(1'b0, 1'b1, 1'b0);
        repeat (45) drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (bcd1 === 8'h00 && running1 === 1'b0 && term1 === 1'b0) passes++;
        else $display("FAIL clr_tick_edge: got %h run %b term %b want 00 0 0", bcd1, running1, term1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        repeat (45) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bcd1 === 8'h46 && running1 === 1'b0 && bcd0 === 8'h46) passes++;
        else $display("FAIL tick_edge: got %h/%h run %b want 46/46 0", bcd0, bcd1, running1);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bcd1 === 8'h46) passes++;
        else $display("FAIL idle_tick: got %h want 46", bcd1);
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        repeat (37) drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bcd1 === 8'h37 && running1 === 1'b1) passes++;
        else $display("FAIL preload37: got %h run %b want 37 1", bcd1, running1);
        @(negedge clk);
        #1;
        tick = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (obs === 20'h0) passes++;
        else $display("FAIL async_reset: got %h want 00000", obs);
        model_reset();
        @(negedge clk);
        rst = 1'b0; tick = 1'b0; btn_run = 1'b0;
    endtask

    task automatic test_dir();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        dir = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bcd1 === (DOWN_EN ? 8'h00 : 8'h02) && term1 === 1'b0) passes++;
        else $display("FAIL dir_step1: got %h term %b want %h 0", bcd1, term1, DOWN_EN ? 8'h00 : 8'h02);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bcd1 === (DOWN_EN ? 8'h99 : 8'h03) && term1 === DOWN_EN) passes++;
        else $display("FAIL dir_step2: got %h term %b want %h %b", bcd1, term1, DOWN_EN ? 8'h99 : 8'h03, DOWN_EN);
        dir = 1'b0;
    endtask

    task automatic test_random();
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            dir = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0));
        end
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 120; i++) begin
            dir = 1'($urandom_range(0, 1));
            drive(1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_terminal();
        test_collision();
        test_mid_reset();
        test_dir();
        test_random();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL queue_drain: %0d entries left want 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
